// File: rtl/rpi_read_port.sv
// rpi_read_port
// Read-side bridge between the clk50 event FIFO and the RPi bit-banged reader.
// The RPi strobes (rd_clk_async / rd_en_async) are synchronised into clk50.
// Each accepted rising edge of the strobe pops one FIFO word onto otube.
// The word is held on otube with rd_valid until the next accepted strobe.
// A latched STOP_WORD marks the end of an event frame. Sticky error flags
// report underflow, overrun and read timeout.
//
// Optional feature macro: READ_PARITY_EN
//   When defined, adds output rd_parity = ^otube. It is registered together
//   with otube, and the RPi uses it for an even-parity check on each word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | otube/rd_valid hold; waiting for an accepted strobe
// ST_POP  | fifo_rd_en was pulsed last edge; arm the latency timer
// ST_WAIT | waiting up to LAT_MAX cycles for fifo_valid

module rpi_read_port #(
  parameter int                SYNC_STAGES = 2,
  parameter int                DATA_W      = 16,
  parameter int                LAT_MAX     = 4,
  parameter logic [DATA_W-1:0] STOP_WORD   = {DATA_W{1'b1}}
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              rd_clk_async,
  input  logic              rd_en_async,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] otube,
  output logic              rd_valid,
  output logic              rd_empty,
  output logic              frame_done,
  output logic [7:0]        word_cnt,
  output logic [2:0]        err_flags
`ifdef READ_PARITY_EN
  ,
  output logic              rd_parity
`endif
);

  // The timer counts down from LAT_MAX-1 to 0, so the counter covers LAT_MAX
  // cycles in WAIT. Those are the cycles fifo_rd_en+1 .. fifo_rd_en+LAT_MAX.
  localparam int CNT_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic                   clk_s_d;
  logic                   accept_r;
  logic                   rd_clk_s;
  logic                   rd_en_s;
  logic                   latch_word;

  assign rd_clk_s = clk_sync[SYNC_STAGES-1];
  assign rd_en_s  = en_sync[SYNC_STAGES-1];

  // A word is taken whenever the FIFO answers while a pop is outstanding.
  // A late fifo_valid that arrives in IDLE (after a timeout or a reset) is ignored.
  assign latch_word = fifo_valid && ((state == ST_POP) || (state == ST_WAIT));

  // Synchronise both strobes, then register the accept pulse.
  // The accept register adds the extra cycle, so fifo_rd_en comes SYNC_STAGES+2 cycles after the strobe.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      en_sync  <= '0;
      clk_s_d  <= 1'b0;
      accept_r <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], rd_clk_async};
      en_sync  <= {en_sync[SYNC_STAGES-2:0], rd_en_async};
      clk_s_d  <= rd_clk_s;
      accept_r <= rd_clk_s & ~clk_s_d & rd_en_s;
    end
  end

  // Registered copy of the FIFO empty flag, used to gate pops.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      rd_empty <= 1'b0;
    end else begin
      rd_empty <= fifo_empty;
    end
  end

  // Read sequencer: pop, wait for data with a timeout, and record errors.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      fifo_rd_en <= 1'b0;
      rd_valid   <= 1'b0;
      err_flags  <= 3'b000;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_r) begin
            rd_valid <= 1'b0;
            if (!rd_empty) begin
              fifo_rd_en <= 1'b1;
              state      <= ST_POP;
            end else begin
              err_flags[0] <= 1'b1;
            end
          end
        end

        ST_POP: begin
          if (accept_r) begin
            err_flags[1] <= 1'b1;
          end
          if (fifo_valid) begin
            rd_valid <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= CNT_LOAD;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (accept_r) begin
            err_flags[1] <= 1'b1;
          end
          if (fifo_valid) begin
            rd_valid <= 1'b1;
            state    <= ST_IDLE;
          end else if (wait_cnt == '0) begin
            err_flags[2] <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Word capture, frame marking and the per-frame word counter.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      otube      <= '0;
      frame_done <= 1'b0;
      word_cnt   <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      if (latch_word) begin
        otube <= fifo_dout;
        if (fifo_dout == STOP_WORD) begin
          frame_done <= 1'b1;
          word_cnt   <= 8'd0;
        end else if (word_cnt != 8'hFF) begin
          word_cnt <= word_cnt + 8'd1;
        end
      end
    end
  end

`ifdef READ_PARITY_EN
  // Parity follows otube exactly, so it updates only when a word is latched.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      rd_parity <= 1'b0;
    end else if (latch_word) begin
      rd_parity <= ^fifo_dout;
    end
  end
`endif

endmodule
